// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit for the cs147sec05 datapath.
// Steps FETCH/DECODE/EXE/MEM/WB and drives the CTRL bus and the memory strobes.
// Outputs for a state are computed on the edge that enters it, so they hold for the whole state.
module proc_ctrl_fsm #(
  parameter int unsigned CTRL_W         = 32,
  parameter logic [2:0]  PC_RESET_STATE = 3'd0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExe    = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  // CTRL bit positions
  localparam int unsigned PcLoad  = 0;
  localparam int unsigned PcSel1  = 1;
  localparam int unsigned PcSel2  = 2;
  localparam int unsigned PcSel3  = 3;
  localparam int unsigned IrLoad  = 4;
  localparam int unsigned RegR    = 5;
  localparam int unsigned RegW    = 6;
  localparam int unsigned R1Sel1  = 7;
  localparam int unsigned WaSel1  = 8;
  localparam int unsigned WaSel2  = 9;
  localparam int unsigned WaSel3  = 10;
  localparam int unsigned SpLoad  = 11;
  localparam int unsigned Op1Sel1 = 12;
  localparam int unsigned Op2Sel1 = 13;
  localparam int unsigned Op2Sel2 = 14;
  localparam int unsigned Op2Sel3 = 15;
  localparam int unsigned Op2Sel4 = 16;
  localparam int unsigned WdSel1  = 17;
  localparam int unsigned WdSel3  = 19;
  localparam int unsigned MaSel1  = 20;
  localparam int unsigned MaSel2  = 21;
  localparam int unsigned MdSel1  = 22;
  localparam int unsigned AluLsb  = 23;

  localparam logic [5:0] AluAdd = 6'd1;
  localparam logic [5:0] AluSub = 6'd2;
  localparam logic [5:0] AluMul = 6'd3;
  localparam logic [5:0] AluSrl = 6'd4;
  localparam logic [5:0] AluSll = 6'd5;
  localparam logic [5:0] AluAnd = 6'd6;
  localparam logic [5:0] AluOr  = 6'd7;
  localparam logic [5:0] AluNor = 6'd8;
  localparam logic [5:0] AluSlt = 6'd9;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJmp   = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpPush  = 6'h1b;
  localparam logic [5:0] OpPop   = 6'h1c;
  localparam logic [5:0] OpMuli  = 6'h1d;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll = 6'h01;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2a;
  localparam logic [5:0] FnMul = 6'h2c;

  // R-type ALU operation; 0 marks a funct that is not an ALU op.
  function automatic logic [5:0] r_alu(input logic [5:0] fn);
    case (fn)
      FnAdd:   r_alu = AluAdd;
      FnSub:   r_alu = AluSub;
      FnMul:   r_alu = AluMul;
      FnSrl:   r_alu = AluSrl;
      FnSll:   r_alu = AluSll;
      FnAnd:   r_alu = AluAnd;
      FnOr:    r_alu = AluOr;
      FnNor:   r_alu = AluNor;
      FnSlt:   r_alu = AluSlt;
      default: r_alu = 6'd0;
    endcase
  endfunction

  function automatic logic [28:0] exe_ctrl(input logic [5:0] op, input logic [5:0] fn);
    logic [28:0] c;
    c = '0;
    case (op)
      OpRtype: begin
        c[AluLsb +: 6] = r_alu(fn);
        if (fn == FnSll || fn == FnSrl) c[Op2Sel3] = 1'b1;
      end
      OpAddi: begin c[AluLsb +: 6] = AluAdd; c[Op2Sel2] = 1'b1; end
      OpMuli: begin c[AluLsb +: 6] = AluMul; c[Op2Sel2] = 1'b1; end
      OpSlti: begin c[AluLsb +: 6] = AluSlt; c[Op2Sel2] = 1'b1; end
      OpAndi: c[AluLsb +: 6] = AluAnd;
      OpOri:  c[AluLsb +: 6] = AluOr;
      OpLui:  c[Op2Sel1] = 1'b1;
      OpBeq, OpBne: begin c[AluLsb +: 6] = AluSub; c[Op2Sel4] = 1'b1; end
      OpLw, OpSw:   begin c[AluLsb +: 6] = AluAdd; c[Op2Sel2] = 1'b1; end
      // SP -/+ constant 1
      OpPush: begin c[AluLsb +: 6] = AluSub; c[Op1Sel1] = 1'b1; end
      OpPop:  begin c[AluLsb +: 6] = AluAdd; c[Op1Sel1] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [28:0] wb_ctrl(input logic [5:0] op, input logic [5:0] fn,
                                          input logic flag);
    logic [28:0] c;
    c = '0;
    c[PcLoad] = 1'b1;
    case (op)
      OpRtype: begin
        if (fn == FnJr) c[PcSel1] = 1'b1;
        else if (r_alu(fn) != 6'd0) c[RegW] = 1'b1;
      end
      OpAddi, OpMuli, OpSlti, OpAndi, OpOri, OpLui: begin
        c[RegW] = 1'b1; c[WaSel1] = 1'b1;
      end
      OpLw:   begin c[RegW] = 1'b1; c[WaSel1] = 1'b1; c[WdSel1] = 1'b1; end
      OpPop:  begin c[RegW] = 1'b1; c[WdSel1] = 1'b1; c[SpLoad] = 1'b1; end
      OpPush: c[SpLoad] = 1'b1;
      OpBeq:  c[PcSel2] = flag;
      OpBne:  c[PcSel2] = ~flag;
      OpJmp:  c[PcSel3] = 1'b1;
      OpJal: begin
        c[PcSel3] = 1'b1; c[RegW] = 1'b1;
        c[WaSel2] = 1'b1; c[WaSel3] = 1'b1; c[WdSel3] = 1'b1;
      end
      default: c[PcLoad] = 1'b1;
    endcase
    return c;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [28:0] ctrl_q, ctrl_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [5:0]  funct_q, funct_d;
  logic        flag_q, flag_d;
  logic        r1_push;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^INSTRUCTION[25:6];

  // Next-state and the output values that will hold in that next state
  always_comb begin
    state_d     = StFetch;
    ctrl_d      = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    flag_d      = flag_q;
    case (state_q)
      StFetch: begin
        state_d      = StDecode;
        ctrl_d[RegR] = 1'b1;
      end
      StDecode: begin
        state_d  = StExe;
        opcode_d = INSTRUCTION[31:26];
        funct_d  = INSTRUCTION[5:0];
        ctrl_d   = exe_ctrl(INSTRUCTION[31:26], INSTRUCTION[5:0]);
      end
      StExe: begin
        state_d = StMem;
        flag_d  = ZERO;
        case (opcode_q)
          OpLw:   mem_read_d = 1'b1;
          OpSw:   mem_write_d = 1'b1;
          OpPush: begin mem_write_d = 1'b1; ctrl_d[MaSel1] = 1'b1; ctrl_d[MdSel1] = 1'b1; end
          OpPop:  begin mem_read_d = 1'b1; ctrl_d[MaSel1] = 1'b1; end
          default: ctrl_d = '0;
        endcase
      end
      StMem: begin
        state_d = StWb;
        ctrl_d  = wb_ctrl(opcode_q, funct_q, flag_q);
      end
      StWb: begin
        state_d        = StFetch;
        mem_read_d     = 1'b1;
        ctrl_d[MaSel2] = 1'b1;
        ctrl_d[IrLoad] = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // State and registered outputs; reset aborts any pending write or PC load at once
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= PC_RESET_STATE;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      opcode_q    <= '0;
      funct_q     <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      opcode_q    <= opcode_d;
      funct_q     <= funct_d;
      flag_q      <= flag_d;
    end
  end

  // The IR only holds the new word once DECODE starts, so the push R0 select is formed from it then
  assign r1_push   = (state_q == StDecode) && (INSTRUCTION[31:26] == OpPush);
  assign CTRL      = CTRL_W'(ctrl_q | (29'(r1_push) << R1Sel1));
  assign MEM_READ  = mem_read_q;
  assign MEM_WRITE = mem_write_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: runs instructions through all five states and
// compares STATE, CTRL and the memory strobes with hand-computed values.
module tb_proc_ctrl_fsm;

  localparam logic [31:0] FetchCtrl = 32'h0020_0010;
  localparam logic [31:0] DecCtrl   = 32'h0000_0020;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        ZERO = 1'b0;
  logic [31:0] CTRL;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  STATE;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_ctrl[5];
  logic        obs_rd[5];
  logic        obs_wr[5];
  logic [2:0]  obs_st[5];
  logic [31:0] exp_ctrl[5];
  logic        exp_rd[5];
  logic        exp_wr[5];

  proc_ctrl_fsm #(.CTRL_W(32), .PC_RESET_STATE(3'd0)) dut (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .CTRL(CTRL), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Starts in FETCH just after an edge; records each state's outputs at the falling edge.
  task automatic run_instr(input logic [31:0] ins, input logic z);
    INSTRUCTION = ins;
    ZERO = z;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      obs_st[i]   = STATE;
      obs_ctrl[i] = CTRL;
      obs_rd[i]   = MEM_READ;
      obs_wr[i]   = MEM_WRITE;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_exp(input logic [31:0] dec, input logic [31:0] exe, input logic [31:0] mem,
                         input logic mrd, input logic mwr, input logic [31:0] wb);
    exp_ctrl[0] = FetchCtrl; exp_rd[0] = 1'b1; exp_wr[0] = 1'b0;
    exp_ctrl[1] = dec;       exp_rd[1] = 1'b0; exp_wr[1] = 1'b0;
    exp_ctrl[2] = exe;       exp_rd[2] = 1'b0; exp_wr[2] = 1'b0;
    exp_ctrl[3] = mem;       exp_rd[3] = mrd;  exp_wr[3] = mwr;
    exp_ctrl[4] = wb;        exp_rd[4] = 1'b0; exp_wr[4] = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    #3;
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL reset STATE: got %0d want 0", STATE); end
    checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL reset CTRL: got %h want 0", CTRL); end
    checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin
      errors++; $display("FAIL reset strobes: got %b%b want 00", MEM_READ, MEM_WRITE);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL release STATE: got %0d want 1", STATE); end
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (STATE !== 3'd0 || CTRL !== FetchCtrl) begin
      errors++; $display("FAIL realign FETCH: got %0d/%h want 0/%h", STATE, CTRL, FetchCtrl);
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] ins, exe, wb;
    string nm;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin nm = "add";  ins = 32'h0022_1820; exe = 32'h0080_0000; wb = 32'h41; end
        1: begin nm = "sub";  ins = 32'h0022_1822; exe = 32'h0100_0000; wb = 32'h41; end
        2: begin nm = "sll";  ins = 32'h0001_1041; exe = 32'h0280_8000; wb = 32'h41; end
        3: begin nm = "addi"; ins = 32'h2022_0005; exe = 32'h0080_4000; wb = 32'h141; end
        4: begin nm = "ori";  ins = 32'h3422_0005; exe = 32'h0380_0000; wb = 32'h141; end
        default: begin nm = "jr"; ins = 32'h03E0_0008; exe = 32'h0; wb = 32'h3; end
      endcase
      set_exp(DecCtrl, exe, 32'h0, 1'b0, 1'b0, wb);
      run_instr(ins, 1'b0);
      for (int i = 0; i < 5; i++) begin
        checks++; if (obs_st[i] !== 3'(i)) begin
          errors++; $display("FAIL %s STATE[%0d]: got %0d want %0d", nm, i, obs_st[i], i);
        end
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin
          errors++; $display("FAIL %s CTRL[%0d]: got %h want %h", nm, i, obs_ctrl[i], exp_ctrl[i]);
        end
        checks++; if ({obs_rd[i], obs_wr[i]} !== {exp_rd[i], exp_wr[i]}) begin
          errors++; $display("FAIL %s RD/WR[%0d]: got %b%b want %b%b", nm, i, obs_rd[i], obs_wr[i],
                             exp_rd[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_load_store;
    logic [31:0] ins, wb;
    logic mrd, mwr;
    string nm;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin nm = "lw"; ins = 32'h8C25_0004; mrd = 1'b1; mwr = 1'b0; wb = 32'h0002_0141; end
      else        begin nm = "sw"; ins = 32'hAC25_0004; mrd = 1'b0; mwr = 1'b1; wb = 32'h1; end
      set_exp(DecCtrl, 32'h0080_4000, 32'h0, mrd, mwr, wb);
      run_instr(ins, 1'b0);
      for (int i = 0; i < 5; i++) begin
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin
          errors++; $display("FAIL %s CTRL[%0d]: got %h want %h", nm, i, obs_ctrl[i], exp_ctrl[i]);
        end
        checks++; if ({obs_rd[i], obs_wr[i]} !== {exp_rd[i], exp_wr[i]}) begin
          errors++; $display("FAIL %s RD/WR[%0d]: got %b%b want %b%b", nm, i, obs_rd[i], obs_wr[i],
                             exp_rd[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_branch;
    logic [31:0] ins, wb;
    logic z;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin ins = 32'h1022_0003; z = 1'b1; wb = 32'h5; end
        1: begin ins = 32'h1022_0003; z = 1'b0; wb = 32'h1; end
        2: begin ins = 32'h1422_0003; z = 1'b1; wb = 32'h1; end
        default: begin ins = 32'h1422_0003; z = 1'b0; wb = 32'h5; end
      endcase
      run_instr(ins, z);
      checks++; if (obs_ctrl[2] !== 32'h0101_0000) begin
        errors++; $display("FAIL branch%0d EXE CTRL: got %h want 01010000", k, obs_ctrl[2]);
      end
      checks++; if (obs_ctrl[4] !== wb) begin
        errors++; $display("FAIL branch%0d WB CTRL: got %h want %h", k, obs_ctrl[4], wb);
      end
    end
  endtask

  task automatic test_jump_stack;
    logic [31:0] ins;
    string nm;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          nm = "jal"; ins = 32'h0C00_0010;
          set_exp(DecCtrl, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0008_0649);
        end
        1: begin
          nm = "push"; ins = 32'h6C00_0000;
          set_exp(32'hA0, 32'h0100_1000, 32'h0050_0000, 1'b0, 1'b1, 32'h801);
        end
        default: begin
          nm = "pop"; ins = 32'h7000_0000;
          set_exp(DecCtrl, 32'h0080_1000, 32'h0010_0000, 1'b1, 1'b0, 32'h0002_0841);
        end
      endcase
      run_instr(ins, 1'b0);
      for (int i = 0; i < 5; i++) begin
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin
          errors++; $display("FAIL %s CTRL[%0d]: got %h want %h", nm, i, obs_ctrl[i], exp_ctrl[i]);
        end
        checks++; if ({obs_rd[i], obs_wr[i]} !== {exp_rd[i], exp_wr[i]}) begin
          errors++; $display("FAIL %s RD/WR[%0d]: got %b%b want %b%b", nm, i, obs_rd[i], obs_wr[i],
                             exp_rd[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ins;
    for (int k = 0; k < 2; k++) begin
      ins = (k == 0) ? 32'hFC00_0000 : 32'h0000_003F;
      set_exp(DecCtrl, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1);
      run_instr(ins, 1'b1);
      for (int i = 0; i < 5; i++) begin
        checks++; if (obs_ctrl[i] !== exp_ctrl[i]) begin
          errors++; $display("FAIL illegal%0d CTRL[%0d]: got %h want %h", k, i, obs_ctrl[i], exp_ctrl[i]);
        end
        checks++; if ({obs_rd[i], obs_wr[i]} !== {exp_rd[i], exp_wr[i]}) begin
          errors++; $display("FAIL illegal%0d RD/WR[%0d]: got %b%b want %b%b", k, i, obs_rd[i],
                             obs_wr[i], exp_rd[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_exe;
    INSTRUCTION = 32'hAC25_0004;
    ZERO = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    checks++; if (STATE !== 3'd2) begin errors++; $display("FAIL midexe STATE: got %0d want 2", STATE); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL abort STATE: got %0d want 0", STATE); end
    checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL abort CTRL: got %h want 0", CTRL); end
    checks++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin
      errors++; $display("FAIL abort strobes: got %b%b want 00", MEM_READ, MEM_WRITE);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (MEM_WRITE !== 1'b0 || CTRL !== 32'h0 || STATE !== 3'd0) begin
      errors++; $display("FAIL held reset: got W=%b CTRL=%h STATE=%0d want 0/0/0", MEM_WRITE, CTRL, STATE);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (STATE !== 3'd1) begin errors++; $display("FAIL rerelease STATE: got %0d want 1", STATE); end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_jump_stack();
    test_illegal();
    test_reset_mid_exe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
